regfile_wb_ctrl: RTL

Write-port controller for the 8-entry register file. It sequences the post-reset clear of registers 1..7, because the file's storage has no reset. It then round-robins NREQ writeback requesters onto the file's single write port (WE3/A3/WD3). It also keeps a pending-write scoreboard, which decode uses for stall decisions.

---
 rtl/regfile_ctrl_pkg.sv | 23 ++
 rtl/regfile_wb_ctrl_rr_arbiter.sv | 33 +++
 rtl/regfile_wb_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write-port controller.
// Holds the default geometry of the 8-entry file, the hard-wired zero register
// and the controller state encoding.
package regfile_ctrl_pkg;

  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int DATA_W   = 24;

  localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;

  // INIT clears registers 1..NUM_REGS-1, RUN serves writeback requesters.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_t;

  // Round-robin successor of index idx among n slots.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting at the
// pointer slot and grants the first active requester (one-hot plus index).
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             found
);

  // First requester at or after ptr (with wrap) wins the grant.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the scan so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-port controller for the register file.
// After reset it walks registers 1..NUM_REGS-1 writing zero (the file storage
// itself has no reset), then round-robins NREQ writeback requesters onto the
// single write port (WE3/A3/WD3) and maintains a pending-write scoreboard for
// decode stall decisions.
// Optional build macro REGFILE_WB_BYPASS_EN adds read-port forwarding of the
// in-flight write and moves the scoreboard clear to the handshake edge.
module regfile_wb_ctrl #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_addr,
  input  logic                   flush,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_a3,
  output logic [DATA_W-1:0]      rf_wd3,
  output logic [2**ADDR_W-1:0]   busy,
  output logic                   init_done
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]      byp_a1,
  input  logic [ADDR_W-1:0]      byp_a2,
  input  logic [DATA_W-1:0]      rf_rd1,
  input  logic [DATA_W-1:0]      rf_rd2,
  output logic [DATA_W-1:0]      byp_rd1,
  output logic [DATA_W-1:0]      byp_rd2
`endif
);

  import regfile_ctrl_pkg::*;

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  wb_state_t         state;
  logic [ADDR_W-1:0] init_cnt;
  logic [PTR_W-1:0]  rr_ptr;

  logic [NREQ-1:0]   grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_found;
  logic              run_ok;
  logic              hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic [NREGS-1:0]  busy_d;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .found     (grant_found)
  );

  // Requests are only accepted in RUN and never while a flush discards state.
  assign run_ok    = (state == RUN) && !flush;
  assign req_ready = run_ok ? grant : '0;
  assign hs        = run_ok && grant_found;
  assign sel_addr  = req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(grant_idx) * DATA_W +: DATA_W];

`ifdef REGFILE_WB_BYPASS_EN
  // With forwarding, readers see the value from the handshake onward, so the
  // scoreboard entry can retire at the handshake edge.
  assign clr_en   = hs;
  assign clr_addr = sel_addr;
`else
  // Without forwarding, the entry retires only when the file commits.
  assign clr_en   = rf_we;
  assign clr_addr = rf_a3;
`endif

  // Scoreboard next state: flush wipes, otherwise clear then set so a newer
  // issue to the same register wins over the retiring write.
  always_comb begin
    busy_d = busy;
    if (state == RUN) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        if (clr_en) begin
          busy_d[clr_addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != ZERO_ADDR)) begin
          busy_d[issue_addr] = 1'b1;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  // Controller FSM: clear sequence in INIT, then registered write-port drive
  // and round-robin pointer advance in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      init_cnt  <= ADDR_W'(1);
      rr_ptr    <= '0;
      rf_we     <= 1'b0;
      rf_a3     <= '0;
      rf_wd3    <= '0;
      busy      <= '0;
      init_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      busy <= busy_d;
      case (state)
        INIT: begin
          // The counter wraps to zero after presenting the last register;
          // that cycle is the final INIT write and the exit point.
          if (init_cnt == '0) begin
            state     <= RUN;
            init_done <= 1'b1;
            rf_we     <= 1'b0;
          end else begin
            rf_we    <= 1'b1;
            rf_a3    <= init_cnt;
            rf_wd3   <= '0;
            init_cnt <= init_cnt + ADDR_W'(1);
          end
        end
        RUN: begin
          if (hs) begin
            // Writes to the zero register are accepted but never reach the file.
            rf_we  <= (sel_addr != ZERO_ADDR);
            rf_a3  <= sel_addr;
            rf_wd3 <= sel_data;
            rr_ptr <= PTR_W'(wrap_inc(int'(grant_idx), NREQ));
          end else begin
            rf_we <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Forward the write presented this cycle to matching non-zero read ports.
  always_comb begin
    byp_rd1 = rf_rd1;
    byp_rd2 = rf_rd2;
    if (rf_we && (rf_a3 == byp_a1) && (byp_a1 != ZERO_ADDR)) begin
      byp_rd1 = rf_wd3;
    end
    if (rf_we && (rf_a3 == byp_a2) && (byp_a2 != ZERO_ADDR)) begin
      byp_rd2 = rf_wd3;
    end
  end
`endif

endmodule
